// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : program_loader_if
// Brief    : Byte-stream load port and CPU fetch port of the program loader.
// Revision : 1.0 - initial release
// ============================================================================
interface program_loader_if;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [3:0] fetch_addr;
    logic [7:0] fetch_instr;
    logic       cpu_reset;
    logic       busy;
    logic       error;
    logic [4:0] count;

    // Host / CPU side
    modport master (
        output start, in_valid, in_data, in_last, fetch_addr,
        input  in_ready, fetch_instr, cpu_reset, busy, error, count
    );

    // Loader side
    modport slave (
        input  start, in_valid, in_data, in_last, fetch_addr,
        output in_ready, fetch_instr, cpu_reset, busy, error, count
    );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Clears a 16x8 instruction store, loads a byte stream into it and
//            releases the CPU; LOADER_CHECKSUM_EN adds a trailing checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter logic [7:0] FILL_INSTR = 8'h10
) (
    input  wire logic       clk,
    input  wire logic       reset,
    program_loader_if.slave bus
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_clear = 3'd1;
    localparam logic [2:0] c_st_load  = 3'd2;
    localparam logic [2:0] c_st_run   = 3'd3;
    localparam logic [2:0] c_st_error = 3'd4;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] c_st_check = 3'd5;
    localparam logic [2:0] c_st_load_done = c_st_check;
`else
    localparam logic [2:0] c_st_load_done = c_st_run;
`endif

    localparam int         c_depth      = 16;
    localparam logic [3:0] c_last_addr  = 4'd15;
    localparam logic [4:0] c_count_max  = 5'd16;
    localparam logic [4:0] c_count_last = 5'd15;

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [7:0] r_mem [c_depth];
    logic [3:0] r_clr_addr;
    logic [4:0] r_count;

    logic       w_in_ready;
    logic       w_xfer;
    logic       w_load_xfer;
    logic       w_enter_clear;
    logic       w_ck_ok;
    logic       w_mem_we;
    logic [3:0] w_mem_waddr;
    logic [7:0] w_mem_wdata;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_acc;
    logic [7:0] w_ck_sum;

    assign w_in_ready = (r_state == c_st_load) || (r_state == c_st_check);
    assign w_ck_sum   = r_acc + bus.in_data;
    assign w_ck_ok    = (w_ck_sum == 8'h00);
`else
    assign w_in_ready = (r_state == c_st_load);
    assign w_ck_ok    = 1'b1;
`endif

    assign w_xfer      = bus.in_valid && w_in_ready;
    assign w_load_xfer = w_xfer && (r_state == c_st_load);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle, c_st_run, c_st_error: begin
                if (bus.start) begin
                    w_state_next = c_st_clear;
                end
            end
            c_st_clear: begin
                if (r_clr_addr == c_last_addr) begin
                    w_state_next = c_st_load;
                end
            end
            c_st_load: begin
                // Store holds 16 entries, so the 16th byte ends the load even without in_last
                if (w_xfer && (bus.in_last || (r_count == c_count_last))) begin
                    w_state_next = c_st_load_done;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            c_st_check: begin
                if (w_xfer) begin
                    w_state_next = w_ck_ok ? c_st_run : c_st_error;
                end
            end
`endif
            default: w_state_next = c_st_idle;
        endcase
    end

    assign w_enter_clear = (r_state != c_st_clear) && (w_state_next == c_st_clear);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_clr_addr <= 4'd0;
            r_count    <= 5'd0;
        end else begin
            r_state <= w_state_next;
            if (w_enter_clear) begin
                r_clr_addr <= 4'd0;
                r_count    <= 5'd0;
            end else begin
                if (r_state == c_st_clear) begin
                    r_clr_addr <= r_clr_addr + 4'd1;
                end
                if (w_load_xfer && (r_count != c_count_max)) begin
                    r_count <= r_count + 5'd1;
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= 8'h00;
        end else if (w_enter_clear) begin
            r_acc <= 8'h00;
        end else if (w_load_xfer) begin
            r_acc <= w_ck_sum;
        end
    end
`endif

    // Single write port shared by the clear sweep and the byte stream
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = r_count[3:0];
        w_mem_wdata = bus.in_data;
        if (r_state == c_st_clear) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_clr_addr;
            w_mem_wdata = FILL_INSTR;
        end else if (w_load_xfer) begin
            w_mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= FILL_INSTR;
            end
        end else if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.fetch_instr = r_mem[bus.fetch_addr];
    assign bus.cpu_reset   = (r_state != c_st_run);
    assign bus.error       = (r_state == c_st_error);
    assign bus.count       = r_count;
`ifdef LOADER_CHECKSUM_EN
    assign bus.busy = (r_state == c_st_clear) || (r_state == c_st_load) ||
                      (r_state == c_st_check);
`else
    assign bus.busy = (r_state == c_st_clear) || (r_state == c_st_load);
`endif

endmodule
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter FILL_INSTR, default 8'h10, SHALL set the instruction written to every unloaded entry (HALT opcode 0001).
REQ-002 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 start  input  1  SHALL be a single-cycle request to begin a program load.
REQ-005 in_valid  input  1  SHALL mark in_data as valid.
REQ-006 in_data  input  8  SHALL carry the instruction byte (or checksum byte).
REQ-007 in_last  input  1  SHALL mark the final program byte, sampled with in_data.
REQ-008 in_ready  output  1  SHALL indicate the loader accepts a byte this cycle.
REQ-009 fetch_addr  input  4  SHALL be the CPU PC fetch address.
REQ-010 fetch_instr  output  8  SHALL return the stored instruction at fetch_addr.
REQ-011 cpu_reset  output  1  SHALL hold the CPU in reset while high.
REQ-012 busy  output  1  SHALL be high in CLEAR, LOAD or CHECK.
REQ-013 error  output  1  SHALL be high in ERROR.
REQ-014 count  output  5  SHALL give the number of program bytes accepted in the current load (0-16).

Function
REQ-015 Storage SHALL be 16 x 8 registers; fetch_instr = mem[fetch_addr], combinational, in every state; a same-cycle write SHALL appear only after the clock edge.
REQ-016 States SHALL be IDLE, CLEAR, LOAD, CHECK, RUN, ERROR; cpu_reset = (state != RUN), decoded combinationally from state.
REQ-017 IDLE: start -> CLEAR, count <= 0.
REQ-018 CLEAR: one entry per cycle, addresses 0..15, written with FILL_INSTR; after writing entry 15 -> LOAD (exactly 16 cycles).
REQ-019 LOAD: in_ready = 1; transfer iff in_valid && in_ready; on transfer mem[count[3:0]] <= in_data, count <= count + 1.
REQ-020 LOAD exit: on a transfer with in_last = 1 or count = 15, go to CHECK if checksum is enabled, else RUN; remaining entries keep FILL_INSTR.
REQ-021 in_valid low in LOAD SHALL stall with no state change; there is no timeout.
REQ-022 in_ready SHALL be 0 in IDLE, CLEAR, RUN and ERROR; in_valid is ignored there.
REQ-023 RUN: start -> CLEAR (reload); cpu_reset reasserts the cycle after start is sampled.
REQ-024 start SHALL be ignored in CLEAR, LOAD and CHECK; in ERROR, start -> CLEAR.
REQ-025 count SHALL saturate at 16 and hold until the next CLEAR entry.

Reset
REQ-026 Reset SHALL force: state IDLE, all mem entries = FILL_INSTR, count = 0, checksum accumulator = 0.
REQ-027 After reset, outputs SHALL be cpu_reset = 1, in_ready = 0, busy = 0, error = 0, fetch_instr = FILL_INSTR.
REQ-028 Reset asserted mid-CLEAR, LOAD or CHECK SHALL abort the load immediately; a partial program is discarded.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined: an 8-bit accumulator SHALL be cleared on entry to CLEAR and add every accepted program byte modulo 256.
REQ-030 With LOADER_CHECKSUM_EN, CHECK SHALL have in_ready = 1; on transfer, (acc + in_data) mod 256 == 0 -> RUN, else -> ERROR; the CHECK byte is not stored or counted.
REQ-031 Without LOADER_CHECKSUM_EN: no CHECK state, no accumulator; LOAD exits straight to RUN.

Verification
REQ-032 Reset, then read all 16 fetch_addr -> each returns 8'h10; cpu_reset = 1, in_ready = 0.
REQ-033 start; 16 cycles of CLEAR; stream 8'hA0..8'hAF with in_last on the last byte (checksum off) -> RUN, cpu_reset = 0 next cycle, mem[5] = 8'hA5, count = 16.
REQ-034 Load 3 bytes 8'h21, 8'h32, 8'h43 with in_last on 8'h43 -> RUN, count = 3, fetch_addr 3..15 = 8'h10.
REQ-035 In LOAD, toggle in_valid 1/0 every cycle over 4 bytes -> exactly 4 writes, with no duplicates and no skipped addresses.
REQ-036 With LOADER_CHECKSUM_EN: bytes 8'h01, 8'h02 (last), checksum 8'hFD -> RUN; repeat with checksum 8'hFE -> ERROR, error = 1, cpu_reset = 1; then start -> CLEAR.
REQ-037 Assert reset after 5 bytes of a LOAD -> IDLE; all entries = 8'h10, count = 0.
